// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the multicycle controller and its datapath.
// master: the controller (takes OP/Zero/mem_ready, drives every control strobe plus debug/status)
// slave:  the datapath side (drives OP/Zero/mem_ready, takes the control strobes)
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       mem_err;
    logic       illegal_op;
    modport master (
        input  OP, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, state, mem_err, illegal_op
    );
    modport slave (
        output OP, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, state, mem_err, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the shared-memory multicycle MIPS datapath.
// Ports: clk, reset (async, active-high), bus (multicycle_control_if.master: OP/Zero/mem_ready in,
//        control strobes, debug state, sticky mem_err and illegal_op out).
// Optional: define CTRL_ILLEGAL_TRAP_EN to make an illegal opcode lock the FSM in TRAP until reset;
//           otherwise an illegal opcode executes as a NOP.
// Strobes that depend only on state/OP are registered from the next state; IRWrite, PCWrite and
// illegal_op follow mem_ready/Zero/OP in the same cycle and are decoded combinationally.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_WIDTH  = 4
) (
    input logic clk,
    input logic reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        RST = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4, MEMWB = 4'd5,
        MEMWR = 4'd6, RTEXE = 4'd7, ITEXE = 4'd8, ALUWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
        TRAP = 4'd12
    } stateT;
    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
    } ctrlT;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam stateT ILLEGAL_NEXT = TRAP;
`else
    localparam stateT ILLEGAL_NEXT = FETCH;
`endif
    stateT                state, nextState;
    logic [CNT_WIDTH-1:0] waitCnt, nextCnt;
    logic                 memErr, memState, timeout, legalOp;
    ctrlT                 ctl;
    function automatic ctrlT decode(input stateT s, input logic [5:0] op);
        ctrlT c;
        c = '0;
        case (s)
            FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = 3'b110; end
            DECODE: begin c.aluSrcB = 2'b11; c.aluOp = 3'b110; end
            MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 3'b110; end
            MEMRD:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
            MEMWB:  begin c.memtoReg = 1'b1; c.regWrite = 1'b1; end
            MEMWR:  begin c.iorD = 1'b1; c.memWrite = 1'b1; end
            RTEXE:  begin c.aluSrcA = 1'b1; c.aluOp = 3'b111; end
            ITEXE:  begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOp   = op == OP_ORI ? 3'b101 : op == OP_ANDI ? 3'b001 : 3'b110;
            end
            ALUWB:  begin c.regWrite = 1'b1; c.regDst = op == OP_R; end
            BRANCH: begin c.aluSrcA = 1'b1; c.aluOp = 3'b010; c.pcSource = 2'b01; end
            JUMP:   c.pcSource = 2'b10;
            default: ;
        endcase
        return c;
    endfunction
    always_comb begin
        legalOp   = bus.OP inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
        memState  = state inside {FETCH, MEMRD, MEMWR};
        // ready in the limit cycle wins, so the abort needs mem_ready low as well
        timeout   = memState && !bus.mem_ready && waitCnt == CNT_WIDTH'(WAIT_LIMIT);
        nextState = FETCH;
        case (state)
            FETCH:  nextState = bus.mem_ready ? DECODE : FETCH;
            DECODE: nextState = (bus.OP == OP_LW || bus.OP == OP_SW) ? MEMADR :
                                bus.OP == OP_R ? RTEXE :
                                (bus.OP == OP_ADDI || bus.OP == OP_ANDI || bus.OP == OP_ORI) ? ITEXE :
                                (bus.OP == OP_BEQ || bus.OP == OP_BNE) ? BRANCH :
                                bus.OP == OP_J ? JUMP : ILLEGAL_NEXT;
            MEMADR: nextState = bus.OP == OP_LW ? MEMRD : MEMWR;
            MEMRD:  nextState = bus.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
            MEMWR:  nextState = (bus.mem_ready || timeout) ? FETCH : MEMWR;
            RTEXE:  nextState = ALUWB;
            ITEXE:  nextState = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:   nextState = TRAP;
`endif
            default: nextState = FETCH;
        endcase
        // an abort re-enters FETCH from FETCH, so it must clear the counter explicitly
        nextCnt = (nextState != state || timeout || !memState || bus.mem_ready) ? '0 : waitCnt + CNT_WIDTH'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RST;
            waitCnt <= '0;
            memErr  <= 1'b0;
            ctl     <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
            memErr  <= memErr | timeout;
            ctl     <= decode(nextState, bus.OP);
        end
    end
    assign bus.IRWrite  = state == FETCH && bus.mem_ready;
    assign bus.PCWrite  = (state == FETCH && bus.mem_ready) || state == JUMP ||
                          (state == BRANCH && ((bus.OP == OP_BEQ && bus.Zero) || (bus.OP == OP_BNE && !bus.Zero)));
    assign bus.IorD     = ctl.iorD;
    assign bus.MemRead  = ctl.memRead;
    assign bus.MemWrite = ctl.memWrite;
    assign bus.RegDst   = ctl.regDst;
    assign bus.MemtoReg = ctl.memtoReg;
    assign bus.RegWrite = ctl.regWrite;
    assign bus.ALUSrcA  = ctl.aluSrcA;
    assign bus.ALUSrcB  = ctl.aluSrcB;
    assign bus.ALUOp    = ctl.aluOp;
    assign bus.PCSource = ctl.pcSource;
    assign bus.state    = state;
    assign bus.mem_err  = memErr;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op = (state == DECODE && !legalOp) || state == TRAP;
`else
    assign bus.illegal_op = state == DECODE && !legalOp;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level random stimulus with a per-cycle expected-output scoreboard.
module tb_multicycle_control;
    localparam int WAIT_LIMIT = 15;
    typedef struct packed {
        logic [3:0] state;
        logic       pcWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       memErr;
        logic       illegalOp;
    } ctlT;
    logic clk = 1'b0;
    logic reset = 1'b1;
    multicycle_control_if bus();
    multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    ctlT        expQ[$];
    ctlT        expVal, actVal;
    int         tests = 0;
    int         failures = 0;
    bit         rstDrive, zero, err;
    logic [5:0] op;
    logic [5:0] legalOps [9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    function automatic bit isLegal(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    endfunction
    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction
    // expected outputs for one cycle spent in phase st, straight from the controller's output table
    function automatic ctlT expv(input int st, input bit rdy, input logic [5:0] o, input bit z, input bit e);
        ctlT c;
        c = '0;
        c.state  = 4'(st);
        c.memErr = e;
        case (st)
            1:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.aluOp = 3'b110; c.irWrite = rdy; c.pcWrite = rdy; end
            2:  begin c.aluSrcB = 2'b11; c.aluOp = 3'b110; c.illegalOp = !isLegal(o); end
            3:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluOp = 3'b110; end
            4:  begin c.iorD = 1; c.memRead = 1; end
            5:  begin c.memtoReg = 1; c.regWrite = 1; end
            6:  begin c.iorD = 1; c.memWrite = 1; end
            7:  begin c.aluSrcA = 1; c.aluOp = 3'b111; end
            8:  begin
                c.aluSrcA = 1;
                c.aluSrcB = 2'b10;
                c.aluOp   = o == 6'h08 ? 3'b110 : o == 6'h0D ? 3'b101 : 3'b001;
            end
            9:  begin c.regWrite = 1; c.regDst = o == 6'h00; end
            10: begin
                c.aluSrcA  = 1;
                c.aluOp    = 3'b010;
                c.pcSource = 2'b01;
                c.pcWrite  = (o == 6'h04 && z) || (o == 6'h05 && !z);
            end
            11: begin c.pcWrite = 1; c.pcSource = 2'b10; end
            12: c.illegalOp = 1;
            default: ;
        endcase
        return c;
    endfunction
    task automatic step(input int st, input bit rdy);
        @(posedge clk);
        #1;
        reset         = rstDrive;
        bus.mem_ready = rdy;
        bus.Zero      = zero;
        bus.OP        = op;
        if (rstDrive) err = 0;
        expQ.push_back(expv(st, rdy, op, zero, err));
    endtask
    task automatic doReset();
        rstDrive = 1;
        step(0, rb());
        step(0, rb());
        rstDrive = 0;
        step(0, rb());
    endtask
    // memory phase: mem_ready rises after lat idle cycles; lat > WAIT_LIMIT means it never does
    task automatic memPhase(input int st, input int lat, output bit ok);
        ok = 0;
        for (int k = 0; k <= WAIT_LIMIT; k++) begin
            step(st, k == lat);
            if (k == lat) begin
                ok = 1;
                return;
            end
        end
        err = 1;
    endtask
    task automatic runInstr(input logic [5:0] o, input bit z, input int fLat, input int mLat);
        bit ok;
        op   = o;
        zero = z;
        memPhase(1, fLat, ok);
        while (!ok) memPhase(1, $urandom_range(0, 2), ok);
        step(2, rb());
        case (o)
            6'h23, 6'h2B: begin
                step(3, rb());
                memPhase(o == 6'h23 ? 4 : 6, mLat, ok);
                if (ok && o == 6'h23) step(5, rb());
            end
            6'h00: begin step(7, rb()); step(9, rb()); end
            6'h08, 6'h0C, 6'h0D: begin step(8, rb()); step(9, rb()); end
            6'h04, 6'h05: step(10, rb());
            6'h02: step(11, rb());
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                repeat (3) step(12, rb());
                doReset();
`endif
            end
        endcase
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                expVal = expQ.pop_front();
                actVal = {bus.state, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                          bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                          bus.PCSource, bus.mem_err, bus.illegal_op};
                tests++;
                if (actVal !== expVal) begin
                    failures++;
                    $display("FAIL ctl @%0t phase %0d: got %h required %h", $time, expVal.state, actVal, expVal);
                end
            end
        end
    end
    initial begin
        logic [5:0] o;
        bit ok;
        rstDrive      = 1;
        zero          = 0;
        err           = 0;
        op            = 6'h00;
        bus.OP        = 6'h00;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        doReset();
        runInstr(6'h08, 0, 0, 0);
        runInstr(6'h23, 0, 0, 3);
        runInstr(6'h05, 0, 1, 0);
        runInstr(6'h04, 0, 0, 0);
        runInstr(6'h23, 1, 15, 15);
        runInstr(6'h2B, 0, 2, 1);
        runInstr(6'h00, 1, 0, 0);
        runInstr(6'h0C, 0, 0, 0);
        runInstr(6'h0D, 0, 0, 0);
        runInstr(6'h02, 0, 0, 0);
        runInstr(6'h3F, 0, 0, 0);
        runInstr(6'h08, 0, 99, 0);
        runInstr(6'h2B, 0, 0, 99);
        op = 6'h2B;
        memPhase(1, 0, ok);
        step(2, 1);
        step(3, 1);
        step(6, 0);
        step(6, 0);
        doReset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                o = 6'($urandom);
                while (isLegal(o)) o = 6'($urandom);
            end else o = legalOps[$urandom_range(0, 8)];
            runInstr(o, rb(), $urandom_range(0, 19) == 0 ? 99 : $urandom_range(0, 3),
                     $urandom_range(0, 19) == 0 ? 99 : $urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) doReset();
        end
        repeat (3) @(posedge clk);
        tests++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d cycles left unchecked, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
